pic_bus_master: RTL and testbench

Synchronous host-side bus initiator for the 8259 PIC cluster: converts single-cycle command requests into properly sequenced chip_select/A0/WR/RD strobe cycles on the shared 8-bit D bus. It also performs the two-pulse INTA acknowledge cycle when the master PIC raises INT_Flag, and returns the captured vector. It sits between the processor model/firmware sequencer and the master/slave `top` instances. ICW/OCW programming and vector fetch become handshaked transactions instead of hand-timed stimulus.

---
 rtl/pic_bus_master_if.sv | 24 ++
 rtl/pic_bus_master.sv | 147 ++++++++++++++
 tb/tb_pic_bus_master.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pic_bus_master_if.sv
// Command/response handshake between the host sequencer and pic_bus_master.
// The requester uses the master modport; the bus initiator block uses the slave modport.
interface pic_bus_master_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic       cmd_a0;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       ack_enable;
  logic       vector_valid;
  logic [7:0] vector;

  modport master (
    output cmd_valid, cmd_write, cmd_a0, cmd_data, ack_enable,
    input  cmd_ready, rsp_valid, rsp_data, vector_valid, vector
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_a0, cmd_data, ack_enable,
    output cmd_ready, rsp_valid, rsp_data, vector_valid, vector
  );
endinterface

// File: rtl/pic_bus_master.sv
// Host-side initiator for the 8259 PIC bus: sequences chip_select/A0/WR/RD
// register cycles and the two-pulse INTA acknowledge that fetches the vector.
module pic_bus_master #(
  parameter int SETUP_CYCLES = 1,
  parameter int PULSE_CYCLES = 2,
  parameter int GAP_CYCLES   = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  pic_bus_master_if.slave host,
  input  logic            INT_Flag,
  output logic            chip_select,
  output logic            A0,
  output logic            WR,
  output logic            RD,
  output logic            INTA,
  inout  wire  [7:0]      D
);

  localparam int MAX_SP = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
  localparam int MAX_CYCLES = (MAX_SP > GAP_CYCLES) ? MAX_SP : GAP_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, INTA1, IGAP, INTA2, IDONE} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_load;
  logic          cnt_zero;
  logic [1:0]    int_meta;
  logic          int_sync;
  logic          arm;
  logic          inta_request;
  logic          accept;
  logic          lat_write, lat_a0;
  logic [7:0]    lat_data;
  logic          write_next, a0_next, bus_next;
  logic          drive;
  logic          rsp_valid, vector_valid;
  logic [7:0]    rsp_data, vector;

  assign int_sync       = int_meta[1];
  assign cnt_zero       = (cnt == '0);
  assign inta_request   = host.ack_enable && int_sync && arm;
  assign host.cmd_ready = (state == IDLE) && !inta_request;
  assign accept         = host.cmd_valid && host.cmd_ready;
  assign write_next     = accept ? host.cmd_write : lat_write;
  assign a0_next        = accept ? host.cmd_a0 : lat_a0;
  assign bus_next       = (state_next == SETUP) || (state_next == STROBE) || (state_next == HOLD);

  assign host.rsp_valid    = rsp_valid;
  assign host.rsp_data     = rsp_data;
  assign host.vector_valid = vector_valid;
  assign host.vector       = vector;

  assign D = drive ? lat_data : 8'bz;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (inta_request) state_next = INTA1;
               else if (accept)  state_next = SETUP;
      SETUP:   if (cnt_zero) state_next = STROBE;
      STROBE:  if (cnt_zero) state_next = HOLD;
      HOLD:    state_next = IDLE;
      INTA1:   if (cnt_zero) state_next = IGAP;
      IGAP:    if (cnt_zero) state_next = INTA2;
      INTA2:   if (cnt_zero) state_next = IDONE;
      IDONE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cnt_load = '0;
    case (state_next)
      SETUP:                cnt_load = CW'(SETUP_CYCLES - 1);
      STROBE, INTA1, INTA2: cnt_load = CW'(PULSE_CYCLES - 1);
      IGAP:                 cnt_load = CW'(GAP_CYCLES - 1);
      default:              cnt_load = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (state_next != state) cnt <= cnt_load;
      else if (!cnt_zero)      cnt <= cnt - 1'b1;
    end
  end

  // arm blocks a second acknowledge until the synchronized request has been seen low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_meta  <= 2'b00;
      arm       <= 1'b1;
      lat_write <= 1'b0;
      lat_a0    <= 1'b1;
      lat_data  <= 8'h00;
    end else begin
      int_meta <= {int_meta[0], INT_Flag};
      if (state == IDLE && inta_request) arm <= 1'b0;
      else if (!int_sync)                arm <= 1'b1;
      if (accept) begin
        lat_write <= host.cmd_write;
        lat_a0    <= host.cmd_a0;
        lat_data  <= host.cmd_data;
      end
    end
  end

  // Pins are registered from the next state so they change cleanly on the clock edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chip_select <= 1'b1;
      A0          <= 1'b1;
      WR          <= 1'b1;
      RD          <= 1'b1;
      INTA        <= 1'b1;
      drive       <= 1'b0;
    end else begin
      chip_select <= !bus_next;
      A0          <= bus_next ? a0_next : 1'b1;
      WR          <= !((state_next == STROBE) && write_next);
      RD          <= !((state_next == STROBE) && !write_next);
      INTA        <= !((state_next == INTA1) || (state_next == INTA2));
      drive       <= bus_next && write_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid    <= 1'b0;
      rsp_data     <= 8'h00;
      vector_valid <= 1'b0;
      vector       <= 8'h00;
    end else begin
      rsp_valid    <= (state == HOLD);
      vector_valid <= (state == IDONE);
      if (state == STROBE && cnt_zero) rsp_data <= lat_write ? 8'h00 : D;
      if (state == INTA2 && cnt_zero)  vector   <= D;
    end
  end

endmodule

// File: tb/tb_pic_bus_master.sv
// Bench for pic_bus_master: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a timeline-based reference model.
module tb_pic_bus_master;
  localparam int S = 1;
  localparam int P = 2;
  localparam int G = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       int_flag = 1'b0;
  logic [7:0] slave_rd_val = 8'h00;
  logic [7:0] slave_vec_val = 8'h00;
  wire        cs, a0, wr, rd, inta;
  wire  [7:0] d_bus;

  int n_compared = 0;
  int n_mismatched = 0;

  pic_bus_master_if host();

  pic_bus_master #(.SETUP_CYCLES(S), .PULSE_CYCLES(P), .GAP_CYCLES(G)) dut (
    .clk(clk), .rst_n(rst_n), .host(host), .INT_Flag(int_flag),
    .chip_select(cs), .A0(a0), .WR(wr), .RD(rd), .INTA(inta), .D(d_bus)
  );

  // PIC stand-in: answers reads and acknowledge pulses on the shared bus
  assign d_bus = !rd ? slave_rd_val : (!inta ? slave_vec_val : 8'bz);

  initial forever #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // ---------------- reference model: expected pin timeline per cycle ----------------
  typedef struct {
    bit cs, a0, wr, rd, inta, drive, rv, vv, cap, cap_rd, cap_vec;
    logic [7:0] d;
  } exp_t;

  exp_t       exp_map[int];
  int         cyc = 0;
  int         last_rst_edge = 0;
  bit         flag_ring[256];
  int         busy_end = 0;
  bit         m_arm = 1'b1;
  logic [7:0] m_rsp = 8'h00, m_vec = 8'h00, pend_rsp = 8'h00, pend_vec = 8'h00;
  bit         has_pend_rsp = 1'b0, has_pend_vec = 1'b0;

  function automatic exp_t idleExp();
    exp_t e;
    e.cs = 1; e.a0 = 1; e.wr = 1; e.rd = 1; e.inta = 1;
    e.drive = 0; e.rv = 0; e.vv = 0; e.cap = 0; e.cap_rd = 0; e.cap_vec = 0;
    e.d = 8'h00;
    return e;
  endfunction

  // synchronized request seen in cycle n is the flag sampled at edge n-1
  function automatic bit syncAt(int n);
    return (n - 1 > last_rst_edge) ? flag_ring[(n - 1) & 255] : 1'b0;
  endfunction

  task automatic scheduleCmd(input int n, input bit w, input bit a, input logic [7:0] dd);
    exp_t e;
    for (int c = n + 1; c <= n + S + P + 1; c++) begin
      e = idleExp();
      e.cs = 0; e.a0 = a; e.drive = w; e.d = dd;
      if (c > n + S && c <= n + S + P) begin
        if (w) e.wr = 0; else e.rd = 0;
      end
      if (c == n + S + P) begin e.cap = 1; e.cap_rd = !w; end
      exp_map[c] = e;
    end
    e = idleExp(); e.rv = 1;
    exp_map[n + S + P + 2] = e;
    busy_end = n + S + P + 2;
  endtask

  task automatic scheduleInta(input int n);
    exp_t e;
    for (int c = n + 1; c <= n + 2 * P + G + 1; c++) begin
      e = idleExp();
      if (c <= n + P || (c > n + P + G && c <= n + 2 * P + G)) e.inta = 0;
      if (c == n + 2 * P + G) e.cap_vec = 1;
      exp_map[c] = e;
    end
    e = idleExp(); e.vv = 1;
    exp_map[n + 2 * P + G + 2] = e;
    busy_end = n + 2 * P + G + 2;
  endtask

  task automatic modelStep();
    int n;
    exp_t e;
    bit s, start, exp_ready;
    n = cyc;
    if (!rst_n) begin
      exp_map.delete();
      busy_end = 0; m_arm = 1; m_rsp = 8'h00; m_vec = 8'h00;
      has_pend_rsp = 0; has_pend_vec = 0;
      return;
    end
    if (has_pend_rsp) begin m_rsp = pend_rsp; has_pend_rsp = 0; end
    if (has_pend_vec) begin m_vec = pend_vec; has_pend_vec = 0; end
    s = syncAt(n);
    start = 0;
    exp_ready = 0;
    if (n >= busy_end) begin
      if (host.ack_enable && s && m_arm) begin
        start = 1;
        scheduleInta(n);
      end else begin
        exp_ready = 1;
        if (host.cmd_valid) scheduleCmd(n, host.cmd_write, host.cmd_a0, host.cmd_data);
      end
    end
    e = exp_map.exists(n) ? exp_map[n] : idleExp();
    checkOutput("cmd_ready", host.cmd_ready, exp_ready);
    checkOutput("chip_select", cs, e.cs);
    checkOutput("A0", a0, e.a0);
    checkOutput("WR", wr, e.wr);
    checkOutput("RD", rd, e.rd);
    checkOutput("INTA", inta, e.inta);
    checkOutput("rsp_valid", host.rsp_valid, e.rv);
    checkOutput("vector_valid", host.vector_valid, e.vv);
    checkOutput("rsp_data", host.rsp_data, m_rsp);
    checkOutput("vector", host.vector, m_vec);
    if (e.drive) checkOutput("D_write", d_bus, e.d);
    if (e.cap) begin pend_rsp = e.cap_rd ? slave_rd_val : 8'h00; has_pend_rsp = 1; end
    if (e.cap_vec) begin pend_vec = slave_vec_val; has_pend_vec = 1; end
    exp_map.delete(n);
    if (start) m_arm = 0;
    else if (!s) m_arm = 1;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    flag_ring[cyc & 255] = int_flag;
    if (!rst_n) last_rst_edge = cyc;
  end

  initial forever begin
    @(negedge clk);
    modelStep();
  end

  // ---------------- stimulus ----------------
  task automatic applyStimulus(input bit w, input bit a, input logic [7:0] dd);
    bit ok;
    ok = 0;
    @(posedge clk); #1;
    host.cmd_valid = 1; host.cmd_write = w; host.cmd_a0 = a; host.cmd_data = dd;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (host.cmd_ready) begin ok = 1; break; end
    end
    if (!ok) checkOutput("cmd_accept_timeout", ok, 1);
    @(posedge clk); #1;
    host.cmd_valid = 0;
  endtask

  task automatic profile(input int cycles, input int start, output int cs_low, output int wr_low,
                         output int rd_low, output int inta_low, output int first_inta,
                         output int rsp_at, output int vv_at, output logic [7:0] d_first);
    cs_low = 0; wr_low = 0; rd_low = 0; inta_low = 0; first_inta = -1;
    rsp_at = 0; vv_at = 0; d_first = 8'h00;
    for (int k = start; k < start + cycles; k++) begin
      @(negedge clk);
      if (!cs) cs_low++;
      if (!wr) wr_low++;
      if (!rd) rd_low++;
      if (!inta) begin inta_low++; if (first_inta < 0) first_inta = k; end
      if (host.rsp_valid && rsp_at == 0) rsp_at = k;
      if (host.vector_valid && vv_at == 0) vv_at = k;
      if (k == start) d_first = d_bus;
    end
  endtask

  initial begin
    int cs_low, wr_low, rd_low, inta_low, first_inta, rsp_at, vv_at, ready_at;
    logic [7:0] d_first;
    host.cmd_valid = 0; host.cmd_write = 0; host.cmd_a0 = 0; host.cmd_data = 8'h00;
    host.ack_enable = 0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_chip_select", cs, 1);
    checkOutput("reset_A0", a0, 1);
    checkOutput("reset_WR", wr, 1);
    checkOutput("reset_RD", rd, 1);
    checkOutput("reset_INTA", inta, 1);
    checkOutput("reset_cmd_ready", host.cmd_ready, 1);
    checkOutput("reset_rsp_data", host.rsp_data, 8'h00);
    checkOutput("reset_vector", host.vector, 8'h00);
    rst_n = 1;
    repeat (2) @(posedge clk);

    $display("[TB] ICW1 write");
    applyStimulus(1, 0, 8'h11);
    profile(10, 1, cs_low, wr_low, rd_low, inta_low, first_inta, rsp_at, vv_at, d_first);
    checkOutput("icw1_cs_low_cycles", cs_low, 4);
    checkOutput("icw1_wr_low_cycles", wr_low, 2);
    checkOutput("icw1_D_cycle1", d_first, 8'h11);
    checkOutput("icw1_rsp_cycle", rsp_at, 5);
    checkOutput("icw1_rsp_data", host.rsp_data, 8'h00);

    $display("[TB] OCW3 then IRR read");
    applyStimulus(1, 0, 8'h0A);
    profile(8, 1, cs_low, wr_low, rd_low, inta_low, first_inta, rsp_at, vv_at, d_first);
    slave_rd_val = 8'h10;
    applyStimulus(0, 0, 8'h00);
    profile(8, 1, cs_low, wr_low, rd_low, inta_low, first_inta, rsp_at, vv_at, d_first);
    checkOutput("read_rd_low_cycles", rd_low, 2);
    checkOutput("read_wr_low_cycles", wr_low, 0);
    checkOutput("read_rsp_cycle", rsp_at, 5);
    checkOutput("read_rsp_data", host.rsp_data, 8'h10);

    $display("[TB] INTA acknowledge");
    slave_vec_val = 8'h0C;
    host.ack_enable = 1;
    @(posedge clk); #1;
    int_flag = 1;
    profile(14, 0, cs_low, wr_low, rd_low, inta_low, first_inta, rsp_at, vv_at, d_first);
    checkOutput("inta_latency", first_inta, 3);
    checkOutput("inta_low_cycles", inta_low, 4);
    checkOutput("inta_cs_low_cycles", cs_low, 0);
    checkOutput("inta_vv_cycle", vv_at, 10);
    checkOutput("inta_vector", host.vector, 8'h0C);

    $display("[TB] re-arm");
    profile(20, 0, cs_low, wr_low, rd_low, inta_low, first_inta, rsp_at, vv_at, d_first);
    checkOutput("held_flag_no_second_inta", inta_low, 0);
    @(posedge clk); #1;
    int_flag = 0;
    @(posedge clk); #1;
    int_flag = 1;
    profile(16, 0, cs_low, wr_low, rd_low, inta_low, first_inta, rsp_at, vv_at, d_first);
    checkOutput("rearm_inta_low_cycles", inta_low, 4);
    checkOutput("rearm_vv_seen", (vv_at > 0), 1);
    @(posedge clk); #1;
    int_flag = 0;
    repeat (5) @(posedge clk);

    $display("[TB] collision");
    @(posedge clk); #1;
    int_flag = 1;
    @(posedge clk);
    @(posedge clk); #1;
    host.cmd_valid = 1; host.cmd_write = 1; host.cmd_a0 = 1; host.cmd_data = 8'h55;
    ready_at = -1; vv_at = -1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (k == 0) checkOutput("collision_ready_low", host.cmd_ready, 0);
      if (host.vector_valid && vv_at < 0) vv_at = k;
      if (host.cmd_ready) begin ready_at = k; break; end
    end
    checkOutput("collision_vv_cycle", vv_at, 8);
    checkOutput("collision_ready_cycle", ready_at, 8);
    @(posedge clk); #1;
    host.cmd_valid = 0;
    int_flag = 0;
    profile(8, 1, cs_low, wr_low, rd_low, inta_low, first_inta, rsp_at, vv_at, d_first);
    checkOutput("collision_cmd_rsp_cycle", rsp_at, 5);
    repeat (4) @(posedge clk);

    $display("[TB] reset mid-strobe");
    applyStimulus(1, 1, 8'hA5);
    @(negedge clk);
    @(negedge clk);
    checkOutput("pre_reset_WR", wr, 0);
    #1;
    rst_n = 0;
    #1;
    checkOutput("async_reset_WR", wr, 1);
    checkOutput("async_reset_chip_select", cs, 1);
    checkOutput("async_reset_A0", a0, 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    profile(10, 1, cs_low, wr_low, rd_low, inta_low, first_inta, rsp_at, vv_at, d_first);
    checkOutput("after_reset_no_rsp", rsp_at, 0);
    checkOutput("after_reset_no_vv", vv_at, 0);
    slave_rd_val = 8'h3C;
    applyStimulus(0, 1, 8'h00);
    profile(8, 1, cs_low, wr_low, rd_low, inta_low, first_inta, rsp_at, vv_at, d_first);
    checkOutput("after_reset_rsp_cycle", rsp_at, 5);
    checkOutput("after_reset_rsp_data", host.rsp_data, 8'h3C);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      host.cmd_valid  = 1'($urandom_range(0, 1));
      host.cmd_write  = 1'($urandom_range(0, 1));
      host.cmd_a0     = 1'($urandom_range(0, 1));
      host.cmd_data   = 8'($urandom);
      host.ack_enable = ($urandom_range(0, 7) != 0);
      slave_rd_val    = 8'($urandom);
      slave_vec_val   = 8'($urandom);
      if ($urandom_range(0, 29) == 0) int_flag = ~int_flag;
    end
    @(posedge clk); #1;
    host.cmd_valid = 0;
    int_flag = 0;
    repeat (20) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #1000000;
    n_mismatched++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
